axil_register_responder: RTL and testbench



---
 rtl/axil_register_responder_pkg.sv | 22 ++
 rtl/axil_register_responder_if.sv | 36 +++
 rtl/axil_register_responder_decoder.sv | 30 +++
 rtl/axil_register_responder.sv | 206 ++++++++++++++++++++
 tb/tb_axil_register_responder.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axil_register_responder_pkg.sv
// Shared types for the AXI4-Lite register responder.
// Contents: AXI response codes, write-channel FSM states, index width helper.
package axil_responder_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axil_resp_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_COMMIT,
        W_RESP
    } write_state_t;

    // Register index width; a single-register bank still needs one index bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axil_register_responder_if.sv
// AXI4-Lite bus bundle for the register responder.
// Channels: AW (awaddr/awvalid/awready), W (wdata/wstrb/wvalid/wready),
// B (bresp/bvalid/bready), AR (araddr/arvalid/arready), R (rdata/rresp/rvalid/rready).
// Modports: master (interconnect side), slave (responder side).
interface axil_register_responder_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_register_responder_decoder.sv
// Combinational address decoder: maps a byte address onto a register slot.
// Ports: addr_i (byte address), hit_c (address inside the bank), index_c (register index).
module axil_address_decoder
    import axil_responder_pkg::*;
#(
    parameter int unsigned          ADDR_WIDTH   = 32,
    parameter int unsigned          DATA_WIDTH   = 32,
    parameter int unsigned          N_REGISTERS  = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS = '0,
    localparam int unsigned         IDX_W        = idx_width(N_REGISTERS)
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic                  hit_c,
    output logic [IDX_W-1:0]      index_c
);

    localparam int unsigned ADDR_LSB = $clog2(DATA_WIDTH / 8);

    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] slot;

    // Sub-word address bits are ignored; the bounds check uses the full slot number.
    always_comb begin
        offset  = addr_i - BASE_ADDRESS;
        slot    = offset >> ADDR_LSB;
        hit_c   = (addr_i >= BASE_ADDRESS) && (slot < ADDR_WIDTH'(N_REGISTERS));
        index_c = IDX_W'(slot);
    end

endmodule

// File: rtl/axil_register_responder.sv
// AXI4-Lite responder terminating a bus branch in a bank of control registers.
// Ports: clock, reset (async, active-low), axil (slave modport of the AXI-Lite bundle),
//        registers (flattened bank, register i at [i*DATA_WIDTH +: DATA_WIDTH]),
//        write_pulse (one-cycle strobe per updated register).
// Build option: AXIL_RESPONDER_DECERR_EN makes out-of-range accesses answer DECERR
// instead of OKAY.
module axil_register_responder
    import axil_responder_pkg::*;
#(
    parameter int unsigned           N_REGISTERS  = 8,
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS = '0
) (
    input  logic                              clock,
    input  logic                              reset,
    axil_register_responder_if.slave          axil,
    output logic [N_REGISTERS*DATA_WIDTH-1:0] registers,
    output logic [N_REGISTERS-1:0]            write_pulse
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned IDX_W  = idx_width(N_REGISTERS);

`ifdef AXIL_RESPONDER_DECERR_EN
    localparam axil_resp_t MISS_RESP = DECERR;
`else
    localparam axil_resp_t MISS_RESP = OKAY;
`endif

    write_state_t          state_q, state_d;
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    axil_resp_t            bresp_q, bresp_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0] regs_q [N_REGISTERS];
    logic [DATA_WIDTH-1:0] regs_d [N_REGISTERS];
    logic [N_REGISTERS-1:0] pulse_q, pulse_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    axil_resp_t            rresp_q, rresp_d;

    logic                  wr_hit, rd_hit;
    logic [IDX_W-1:0]      wr_idx, rd_idx;
    logic                  ar_ready_c;

    // Write decode works on the latched address, read decode on the live AR address.
    axil_address_decoder #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .N_REGISTERS (N_REGISTERS),
        .BASE_ADDRESS(BASE_ADDRESS)
    ) u_wr_decode (
        .addr_i (awaddr_q),
        .hit_c  (wr_hit),
        .index_c(wr_idx)
    );

    axil_address_decoder #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .N_REGISTERS (N_REGISTERS),
        .BASE_ADDRESS(BASE_ADDRESS)
    ) u_rd_decode (
        .addr_i (axil.araddr),
        .hit_c  (rd_hit),
        .index_c(rd_idx)
    );

    // Write channel: collect AW and W in any order, commit, then hold B until accepted.
    always_comb begin
        state_d   = state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        regs_d    = regs_q;
        pulse_d   = '0;

        unique case (state_q)
            W_IDLE: begin
                if (axil.awvalid && awready_q) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = axil.awaddr;
                    awready_d = 1'b0;
                end
                if (axil.wvalid && wready_q) begin
                    w_held_d = 1'b1;
                    wdata_d  = axil.wdata;
                    wstrb_d  = axil.wstrb;
                    wready_d = 1'b0;
                end
                if (aw_held_d && w_held_d) begin
                    state_d = W_COMMIT;
                end
            end
            W_COMMIT: begin
                if (wr_hit) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (wstrb_q[b]) begin
                            regs_d[wr_idx][b*8 +: 8] = wdata_q[b*8 +: 8];
                        end
                    end
                    // An all-zero strobe is a legal no-op and must not pulse.
                    pulse_d[wr_idx] = |wstrb_q;
                    bresp_d         = OKAY;
                end else begin
                    bresp_d = MISS_RESP;
                end
                bvalid_d = 1'b1;
                state_d  = W_RESP;
            end
            W_RESP: begin
                if (axil.bready) begin
                    bvalid_d  = 1'b0;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    state_d   = W_IDLE;
                end
            end
            default: state_d = W_IDLE;
        endcase
    end

    // Read channel: a new request may enter whenever the R slot is empty or draining.
    assign ar_ready_c = !rvalid_q || axil.rready;

    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (axil.arvalid && ar_ready_c) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_hit ? regs_q[rd_idx] : '0;
            rresp_d  = rd_hit ? OKAY : MISS_RESP;
        end else if (axil.rready) begin
            rvalid_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            for (int i = 0; i < N_REGISTERS; i++) begin
                regs_q[i] <= '0;
            end
            pulse_q   <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= OKAY;
        end else begin
            state_q   <= state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            regs_q    <= regs_d;
            pulse_q   <= pulse_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign axil.awready = awready_q;
    assign axil.wready  = wready_q;
    assign axil.bvalid  = bvalid_q;
    assign axil.bresp   = bresp_q;
    assign axil.arready = ar_ready_c;
    assign axil.rvalid  = rvalid_q;
    assign axil.rdata   = rdata_q;
    assign axil.rresp   = rresp_q;
    assign write_pulse  = pulse_q;

    for (genvar i = 0; i < N_REGISTERS; i++) begin : g_flat
        assign registers[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end

endmodule

// File: tb/tb_axil_register_responder.sv
// Directed bench for axil_register_responder with B/R response scoreboards.
module tb_axil_register_responder;

    localparam int unsigned NR   = 8;
    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned CW   = NR * DW;
    localparam logic [31:0] BASE = 32'h0000_1000;
`ifdef AXIL_RESPONDER_DECERR_EN
    localparam logic [1:0] MISS = 2'b11;
`else
    localparam logic [1:0] MISS = 2'b00;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axil_register_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    logic [CW-1:0] registers;
    logic [NR-1:0] write_pulse;

    axil_register_responder #(
        .N_REGISTERS (NR),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .BASE_ADDRESS(BASE)
    ) dut (
        .clock      (clk),
        .reset      (rst_n),
        .axil       (bus),
        .registers  (registers),
        .write_pulse(write_pulse)
    );

    typedef struct packed { logic [1:0] resp; logic [NR-1:0] pulse; } b_exp_t;
    typedef struct packed { logic [1:0] resp; logic [DW-1:0] data; } r_exp_t;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] model [NR];
    b_exp_t      b_q [$];
    r_exp_t      r_q [$];

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] model_flat();
        logic [CW-1:0] f;
        for (int i = 0; i < NR; i++) f[i*DW +: DW] = model[i];
        return f;
    endfunction

    function automatic logic decode(input logic [31:0] addr, output int idx);
        idx = 0;
        if (addr < BASE || addr >= BASE + 32'(4 * NR)) return 1'b0;
        idx = int'((addr - BASE) >> 2);
        return 1'b1;
    endfunction

    // Scoreboard entry for a write; the model is updated as the DUT should be at commit.
    task automatic expect_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        b_exp_t e;
        int     idx;
        e.pulse = '0;
        if (decode(addr, idx)) begin
            e.resp = 2'b00;
            for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
            if (strb != 4'h0) e.pulse[idx] = 1'b1;
        end else begin
            e.resp = MISS;
        end
        b_q.push_back(e);
    endtask

    task automatic expect_read(input logic [31:0] addr);
        r_exp_t e;
        int     idx;
        if (decode(addr, idx)) begin
            e.resp = 2'b00;
            e.data = model[idx];
        end else begin
            e.resp = MISS;
            e.data = '0;
        end
        r_q.push_back(e);
    endtask

    task automatic send_aw(input logic [31:0] addr);
        int   n  = 0;
        logic hs = 1'b0;
        bus.awaddr  = addr;
        bus.awvalid = 1'b1;
        while (!hs && n < 20) begin
            #1 hs = bus.awready;
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        bus.awvalid = 1'b0;
        check("aw_accept", CW'(hs), CW'(1));
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
        int   n  = 0;
        logic hs = 1'b0;
        bus.wdata  = data;
        bus.wstrb  = strb;
        bus.wvalid = 1'b1;
        while (!hs && n < 20) begin
            #1 hs = bus.wready;
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        bus.wvalid = 1'b0;
        check("w_accept", CW'(hs), CW'(1));
    endtask

    task automatic recv_b(input int stall);
        int     n = 0;
        b_exp_t e;
        while (bus.bvalid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b_valid", CW'(bus.bvalid), CW'(1));
        check("b_queue", CW'(b_q.size() != 0), CW'(1));
        if (b_q.size() != 0) begin
            e = b_q.pop_front();
            check("bresp", CW'(bus.bresp), CW'(e.resp));
            check("write_pulse", CW'(write_pulse), CW'(e.pulse));
            check("registers", registers, model_flat());
            for (int k = 0; k < stall; k++) begin
                @(negedge clk);
                check("b_stall_valid", CW'(bus.bvalid), CW'(1));
                check("b_stall_resp", CW'(bus.bresp), CW'(e.resp));
                check("b_stall_awready", CW'(bus.awready), CW'(0));
                check("b_stall_wready", CW'(bus.wready), CW'(0));
            end
        end
        bus.bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.bready = 1'b0;
        check("b_drop", CW'(bus.bvalid), CW'(0));
        check("pulse_single", CW'(write_pulse), CW'(0));
        check("awready_back", CW'(bus.awready), CW'(1));
    endtask

    task automatic write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                         input int stall);
        expect_write(addr, data, strb);
        fork
            send_aw(addr);
            send_w(data, strb);
        join
        recv_b(stall);
    endtask

    task automatic pop_r();
        r_exp_t e;
        check("r_valid", CW'(bus.rvalid), CW'(1));
        check("r_queue", CW'(r_q.size() != 0), CW'(1));
        if (r_q.size() != 0) begin
            e = r_q.pop_front();
            check("rdata", CW'(bus.rdata), CW'(e.data));
            check("rresp", CW'(bus.rresp), CW'(e.resp));
        end
    endtask

    task automatic read(input logic [31:0] addr);
        int   n  = 0;
        logic hs = 1'b0;
        expect_read(addr);
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b1;
        while (!hs && n < 20) begin
            #1 hs = bus.arready;
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        bus.arvalid = 1'b0;
        check("ar_accept", CW'(hs), CW'(1));
        pop_r();
        @(posedge clk);
        @(negedge clk);
        bus.rready = 1'b0;
        check("r_drop", CW'(bus.rvalid), CW'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout after %0d tests", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_awready", CW'(bus.awready), CW'(1));
        check("rst_wready", CW'(bus.wready), CW'(1));
        check("rst_arready", CW'(bus.arready), CW'(1));
        check("rst_bvalid", CW'(bus.bvalid), CW'(0));
        check("rst_rvalid", CW'(bus.rvalid), CW'(0));
        check("rst_bresp", CW'(bus.bresp), CW'(0));
        check("rst_rresp", CW'(bus.rresp), CW'(0));
        check("rst_rdata", CW'(bus.rdata), CW'(0));
        check("rst_regs", registers, CW'(0));
        check("rst_pulse", CW'(write_pulse), CW'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // AW and W together, then read back
        write(BASE + 32'h4, 32'hDEAD_BEEF, 4'hF, 0);
        check("reg1_value", CW'(registers[1*DW +: DW]), CW'(32'hDEAD_BEEF));
        read(BASE + 32'h4);

        // W three cycles ahead of AW, partial strobe
        write(BASE + 32'h8, 32'hAAAA_AAAA, 4'hF, 0);
        expect_write(BASE + 32'h8, 32'h0000_1234, 4'h3);
        send_w(32'h0000_1234, 4'h3);
        for (int k = 0; k < 3; k++) begin
            check("w_first_wready", CW'(bus.wready), CW'(0));
            check("w_first_bvalid", CW'(bus.bvalid), CW'(0));
            @(negedge clk);
        end
        send_aw(BASE + 32'h8);
        recv_b(0);
        check("reg2_merge", CW'(registers[2*DW +: DW]), CW'(32'hAAAA_1234));

        // B back-pressure, then a follow-on write
        write(BASE + 32'hC, 32'h5555_0001, 4'hF, 5);
        write(BASE + 32'h10, 32'h7777_0002, 4'hF, 0);

        // Zero strobe on a hit: OKAY, no pulse, no change
        write(BASE + 32'h0, 32'h1234_5678, 4'h0, 0);

        // Out-of-range accesses
        write(BASE + 32'h20, 32'hFFFF_FFFF, 4'hF, 0);
        read(BASE + 32'h20);
        read(BASE - 32'h4);
        check("miss_regs", registers, model_flat());

        // Back-to-back reads of every register
        bus.rready = 1'b1;
        for (int i = 0; i < NR; i++) begin
            expect_read(BASE + 32'(4 * i));
            bus.araddr  = BASE + 32'(4 * i);
            bus.arvalid = 1'b1;
            #1 check("b2b_arready", CW'(bus.arready), CW'(1));
            @(posedge clk);
            @(negedge clk);
            pop_r();
        end
        held = model[NR-1];
        bus.rready = 1'b0;
        expect_read(BASE + 32'h4);
        bus.araddr = BASE + 32'h4;
        for (int k = 0; k < 2; k++) begin
            #1 check("stall_arready", CW'(bus.arready), CW'(0));
            check("stall_rvalid", CW'(bus.rvalid), CW'(1));
            check("stall_rdata", CW'(bus.rdata), CW'(held));
            @(posedge clk);
            @(negedge clk);
        end
        bus.rready = 1'b1;
        #1 check("unstall_arready", CW'(bus.arready), CW'(1));
        @(posedge clk);
        @(negedge clk);
        bus.arvalid = 1'b0;
        pop_r();
        @(posedge clk);
        @(negedge clk);
        bus.rready = 1'b0;
        check("b2b_drain", CW'(bus.rvalid), CW'(0));

        // Reset while a B response is pending
        expect_write(BASE + 32'h18, 32'hCAFE_F00D, 4'hF);
        fork
            send_aw(BASE + 32'h18);
            send_w(32'hCAFE_F00D, 4'hF);
        join
        for (int n = 0; n < 20 && bus.bvalid !== 1'b1; n++) @(negedge clk);
        check("pre_rst_bvalid", CW'(bus.bvalid), CW'(1));
        check("pre_rst_regs", registers, model_flat());
        if (b_q.size() != 0) void'(b_q.pop_front());
        rst_n = 1'b0;
        #1;
        check("mid_rst_bvalid", CW'(bus.bvalid), CW'(0));
        check("mid_rst_regs", registers, CW'(0));
        for (int i = 0; i < NR; i++) model[i] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_awready", CW'(bus.awready), CW'(1));
        check("post_rst_wready", CW'(bus.wready), CW'(1));
        check("post_rst_arready", CW'(bus.arready), CW'(1));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("no_spurious_b", CW'(bus.bvalid), CW'(0));
        end

        // Normal operation after reset
        write(BASE + 32'h1C, 32'h0BAD_CAFE, 4'hC, 0);
        read(BASE + 32'h1C);
        check("reg7_upper", CW'(registers[7*DW +: DW]), CW'(32'h0BAD_0000));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
